// File: rtl/operand_sel_pipe_pkg.sv
// Shared definitions for the operand stages: default sizes, the beat record
// and the skid-buffer state encoding.
package operand_sel_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_IN  = 4;
    localparam int DEF_SEL_W = 2;

    // Occupancy of the output/skid register pair.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // One transfer through an operand stage: selected word plus range error.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 err;
    } beat_t;

    function automatic int beat_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/operand_sel_pipe_skid.sv
// Output register plus one-entry skid register with a registered ready, so a
// downstream stall never reaches upstream combinationally.
module skid_buf
    import operand_sel_pipe_pkg::*;
#(
    parameter int W = DEF_WIDTH + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [W-1:0] i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [W-1:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output skid_state_e o_state
);

    // Handshake: a beat moves across an interface on a rising edge where
    // valid and ready are both high; valid never depends on ready.
    skid_state_e r_state;
    skid_state_e w_next_state;
    logic [W-1:0] r_or_data;
    logic [W-1:0] r_sk_data;
    logic w_accept;
    logic w_ld_or_in;
    logic w_ld_or_sk;
    logic w_ld_sk;

    assign o_ready  = !rst && (r_state != SKID_FULL);
    assign w_accept = i_valid && o_ready;

    always_comb begin
        w_next_state = r_state;
        w_ld_or_in   = 1'b0;
        w_ld_or_sk   = 1'b0;
        w_ld_sk      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_ld_or_in   = 1'b1;
                    w_next_state = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (w_accept && i_ready) begin
                    w_ld_or_in = 1'b1;
                end else if (w_accept) begin
                    w_ld_sk      = 1'b1;
                    w_next_state = SKID_FULL;
                end else if (i_ready) begin
                    w_next_state = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (i_ready) begin
                    w_ld_or_sk   = 1'b1;
                    w_next_state = SKID_ONE;
                end
            end
            default: w_next_state = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SKID_EMPTY;
            r_or_data <= '0;
            r_sk_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ld_or_in) begin
                r_or_data <= i_data;
            end else if (w_ld_or_sk) begin
                r_or_data <= r_sk_data;
            end
            if (w_ld_sk) begin
                r_sk_data <= i_data;
            end
        end
    end

    assign o_data  = r_or_data;
    assign o_valid = (r_state != SKID_EMPTY);
    assign o_state = r_state;

endmodule

// File: rtl/operand_sel_pipe.sv
// N-way operand selector: combinational select and range check feeding a
// registered skid buffer; out-of-range selects emit data 0 with err set.
module operand_sel_pipe
    import operand_sel_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_IN  = DEF_N_IN,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } beat_w_t;

    beat_w_t     w_sel_beat;
    beat_w_t     w_out_beat;
    logic        w_skid_valid;
    skid_state_e w_skid_state;

    // Any index without a matching input word falls through as an error.
    always_comb begin
        w_sel_beat.data = '0;
        w_sel_beat.err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_beat.data = in_data[k*WIDTH +: WIDTH];
                w_sel_beat.err  = 1'b0;
            end
        end
    end

    skid_buf #(
        .W(WIDTH + 1)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_sel_beat),
        .i_valid(in_valid),
        .o_ready(in_ready),
        .o_data (w_out_beat),
        .o_valid(w_skid_valid),
        .i_ready(out_ready),
        .o_state(w_skid_state)
    );

    assign out_valid = w_skid_valid && (w_skid_state != SKID_EMPTY);
    assign out_data  = w_out_beat.data;
    assign out_err   = w_out_beat.err;

endmodule
